// File: rtl/poly_diff_engine_pkg.sv
// Shared types and helpers for the forward-difference (Babbage) polynomial engine.
// Imported by the interface, the difference stage and the top level.
package poly_diff_engine_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of the coefficient address; at least one bit even for degenerate orders.
  function automatic int addr_w(input int order);
    return (order < 1) ? 1 : $clog2(order + 1);
  endfunction

endpackage

// File: rtl/poly_diff_engine_if.sv
// Configuration, run-control and result signals of the difference engine.
// The controller side uses master; the engine uses slave.
interface poly_diff_engine_if #(
  parameter int W     = 18,
  parameter int NW    = 6,
  parameter int ORDER = 3
);
  import poly_diff_engine_pkg::*;

  localparam int AW = addr_w(ORDER);

  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [W-1:0]  cfg_data;
  logic          start;
  logic [NW-1:0] n;
  logic          stream;
  logic [W-1:0]  ans;
  logic          ans_valid;
  logic          ready;
  logic          done_tick;
  logic          ovf;

  modport master (
    output cfg_we, cfg_addr, cfg_data, start, n, stream,
    input  ans, ans_valid, ready, done_tick, ovf
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, start, n, stream,
    output ans, ans_valid, ready, done_tick, ovf
  );

endinterface

// File: rtl/poly_diff_engine_diff_stage.sv
// One difference register d[i]: loads Δ^i f(0), or accumulates d[i+1] each step.
// Exposes the carry-out of the accumulation so the top can flag wrap-around.
module diff_stage #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] add_val,
  output logic [W-1:0] q,
  output logic         carry
);

  logic [W-1:0] d_d, d_q;
  logic [W:0]   sum_full;

  assign sum_full = {1'b0, d_q} + {1'b0, add_val};
  assign carry    = sum_full[W];
  assign q        = d_q;

  // NOTE: every variable driven in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    d_d = d_q;
    if (load)      d_d = load_val;
    else if (step) d_d = sum_full[W-1:0];
  end

  // NOTE: state registers use non-blocking assignments so all stages update from the same old values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= '0;
    else        d_q <= d_d;
  end

endmodule

// File: rtl/poly_diff_engine.sv
// Forward-difference engine: evaluates a degree<=ORDER polynomial at n, one add-step per clock,
// optionally streaming every f(k). Holds the coefficient file, the run FSM and the result flags.
module poly_diff_engine
  import poly_diff_engine_pkg::*;
#(
  parameter int W     = 18,
  parameter int NW    = 6,
  parameter int ORDER = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  poly_diff_engine_if.slave   bus
);

  localparam int AW = addr_w(ORDER);

  state_e        state_d, state_q;
  logic [NW-1:0] cnt_d, cnt_q;
  logic          ovf_d, ovf_q;
  logic          stream_d, stream_q;
  logic [W-1:0]  dtop_d, dtop_q;
  logic          load, step;

  logic [W-1:0]     coeff_d [ORDER+1];
  logic [W-1:0]     coeff_q [ORDER+1];
  logic [W-1:0]     d       [ORDER+1];
  logic [ORDER-1:0] carry;

  // Coefficient file: out-of-range addresses match no entry and are dropped.
  always_comb begin
    for (int i = 0; i <= ORDER; i++) begin
      coeff_d[i] = (bus.cfg_we && bus.cfg_addr == AW'(i)) ? bus.cfg_data : coeff_q[i];
    end
  end

  // NOTE: the coefficient file is a handful of flops, not a RAM, so it is reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= ORDER; i++) coeff_q[i] <= '0;
    end else begin
      coeff_q <= coeff_d;
    end
  end

  for (genvar g = 0; g < ORDER; g++) begin : g_stage
    diff_stage #(.W(W)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .step     (step),
      .load_val (coeff_q[g]),
      .add_val  (d[g+1]),
      .q        (d[g]),
      .carry    (carry[g])
    );
  end

  // Highest difference is constant for the whole run.
  assign dtop_d   = load ? coeff_q[ORDER] : dtop_q;
  assign d[ORDER] = dtop_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    stream_d = stream_q;
    load     = 1'b0;
    step     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load     = 1'b1;
          cnt_d    = bus.n;
          ovf_d    = 1'b0;
          stream_d = bus.stream;
          state_d  = (bus.n == '0) ? DONE : STEP;
        end
      end
      STEP: begin
        step  = 1'b1;
        cnt_d = cnt_q - NW'(1);
        ovf_d = ovf_q | (|carry);
        if (cnt_q == NW'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      stream_q <= 1'b0;
      dtop_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      stream_q <= stream_d;
      dtop_q   <= dtop_d;
    end
  end

  // d[0] is only written on load/step edges, so it doubles as the held result register.
  assign bus.ans       = d[0];
  assign bus.ovf       = ovf_q;
  assign bus.ready     = (state_q == IDLE);
  assign bus.done_tick = (state_q == DONE);
  assign bus.ans_valid = (state_q == DONE) || (state_q == STEP && stream_q);

endmodule

// File: tb/tb_poly_diff_engine.sv
// Directed bench for poly_diff_engine: an 18-bit and an 8-bit instance run the same vectors,
// results compared against hand-computed polynomial values.
module tb_poly_diff_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [17:0] cfg_data;
  logic        start;
  logic [5:0]  n;
  logic        stream;

  always #5 clk = ~clk;

  poly_diff_engine_if #(.W(18), .NW(6), .ORDER(3)) b18 ();
  poly_diff_engine_if #(.W(8),  .NW(6), .ORDER(3)) b8  ();

  assign b18.cfg_we   = cfg_we;
  assign b18.cfg_addr = cfg_addr;
  assign b18.cfg_data = cfg_data;
  assign b18.start    = start;
  assign b18.n        = n;
  assign b18.stream   = stream;
  assign b8.cfg_we    = cfg_we;
  assign b8.cfg_addr  = cfg_addr;
  assign b8.cfg_data  = cfg_data[7:0];
  assign b8.start     = start;
  assign b8.n         = n;
  assign b8.stream    = stream;

  poly_diff_engine #(.W(18), .NW(6), .ORDER(3)) u_dut18 (.clk(clk), .rst_n(rst_n), .bus(b18));
  poly_diff_engine #(.W(8),  .NW(6), .ORDER(3)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  logic [17:0] vals[$];
  int lat, lat8;

  task automatic write_coeff(input logic [1:0] a, input logic [17:0] v);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = a; cfg_data = v;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Waits for done on both instances; cycle c is the one following edge E0+(c-1).
  task automatic wait_done(input int first_cycle);
    lat = -1; lat8 = -1;
    for (int c = first_cycle; c < first_cycle + 100 && (lat < 0 || lat8 < 0); c++) begin
      @(negedge clk);
      if (b18.ans_valid) vals.push_back(b18.ans);
      if (b18.done_tick && lat < 0)  lat  = c;
      if (b8.done_tick  && lat8 < 0) lat8 = c;
    end
  endtask

  task automatic run(input int nn, input bit st);
    @(posedge clk); #1;
    start = 1'b1; n = 6'(nn); stream = st;
    @(posedge clk); #1;
    start = 1'b0;
    vals.delete();
    wait_done(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    start = 1'b0; n = '0; stream = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", b18.ready, 1);
    check("rst_ans", b18.ans, 0);
    check("rst_done", b18.done_tick, 0);
    check("rst_valid", b18.ans_valid, 0);
    check("rst_ovf", b18.ovf, 0);
    rst_n = 1'b1;

    // f(n) = n^3
    write_coeff(2'd0, 18'd0);
    write_coeff(2'd1, 18'd1);
    write_coeff(2'd2, 18'd6);
    write_coeff(2'd3, 18'd6);

    run(5, 1'b0);
    check("cube_lat", lat, 6);
    check("cube_ans", b18.ans, 125);
    check("cube_ovf", b18.ovf, 0);
    check("cube_nvalid", vals.size(), 1);
    @(negedge clk);
    check("cube_idle", b18.ready, 1);
    check("cube_hold", b18.ans, 125);

    run(0, 1'b0);
    check("n0_lat", lat, 1);
    check("n0_ans", b18.ans, 0);
    check("n0_nvalid", vals.size(), 1);
    @(negedge clk);
    check("n0_valid_gone", b18.ans_valid, 0);

    run(4, 1'b1);
    check("stream_lat", lat, 5);
    check("stream_nvalid", vals.size(), 5);
    for (int k = 0; k < 5 && k < vals.size(); k++) check($sformatf("stream_val%0d", k), vals[k], k * k * k);
    check("stream_final", b18.ans, 64);

    run(7, 1'b0);
    check("wrap_ans8", b8.ans, 87);
    check("wrap_ovf8", b8.ovf, 1);
    check("wrap_ans18", b18.ans, 343);
    check("wrap_ovf18", b18.ovf, 0);
    run(2, 1'b0);
    check("after_wrap_ans8", b8.ans, 8);
    check("after_wrap_ovf8", b8.ovf, 0);

    // Write to coeff[0] on the accepting edge: the run must see the old value.
    @(posedge clk); #1;
    start = 1'b1; n = 6'd0; stream = 1'b0;
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 18'd5;
    @(posedge clk); #1;
    start = 1'b0; cfg_we = 1'b0;
    @(negedge clk);
    check("coinc_done", b18.done_tick, 1);
    check("coinc_old", b18.ans, 0);
    run(0, 1'b0);
    check("coinc_new", b18.ans, 5);
    write_coeff(2'd0, 18'd0);

    // Busy run n=20: a start pulse and a coefficient write mid-run must not disturb it.
    @(posedge clk); #1;
    start = 1'b1; n = 6'd20; stream = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; n = 6'd2; cfg_we = 1'b1; cfg_addr = 2'd3; cfg_data = 18'd12;
    @(posedge clk); #1;
    start = 1'b0; cfg_we = 1'b0;
    vals.delete();
    wait_done(5);
    check("busy_lat", lat, 21);
    check("busy_ans", b18.ans, 8000);
    @(negedge clk);
    check("busy_no_restart", b18.ready, 1);
    // Complete f = 2n^3: {0, 2, 12, 12}; coeff[3] already written during the busy run.
    write_coeff(2'd1, 18'd2);
    write_coeff(2'd2, 18'd12);
    run(2, 1'b0);
    check("dbl_ans", b18.ans, 16);

    // Asynchronous reset in the middle of an n=10 run.
    @(posedge clk); #1;
    start = 1'b1; n = 6'd10; stream = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_ans", b18.ans, 0);
    check("abort_ready", b18.ready, 1);
    check("abort_ans8", b8.ans, 0);
    lat = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (b18.done_tick && lat < 0) lat = c;
      if (c == 4) rst_n = 1'b1;
    end
    check("abort_no_done", lat, -1);
    run(3, 1'b0);
    check("abort_coeff_zero", b18.ans, 0);
    check("abort_lat", lat, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
